// File: rtl/uninasoc_pkg.sv
// Shared SoC constants for the PLIC: sizes, interrupt line numbers and
// register offsets used by the controller and by software-facing code.
package uninasoc_pkg;

  localparam int unsigned PLIC_NUM_SRC    = 32;
  localparam int unsigned PLIC_PRIO_WIDTH = 3;

  // Interrupt line numbers; each one is the bit index into irq_src_i
  localparam int unsigned PLIC_RESERVED_INTERRUPT = 0;
  localparam int unsigned PLIC_GPIO_INTERRUPT     = 1;
  localparam int unsigned PLIC_TIM0_INTERRUPT     = 2;
  localparam int unsigned PLIC_TIM1_INTERRUPT     = 3;
  localparam int unsigned PLIC_UART_INTERRUPT     = 4;

  localparam logic [7:0] PLIC_PRIORITY_OFFSET  = 8'h00;
  localparam logic [7:0] PLIC_PENDING_OFFSET   = 8'h80;
  localparam logic [7:0] PLIC_ENABLE_OFFSET    = 8'h84;
  localparam logic [7:0] PLIC_EDGE_OFFSET      = 8'h88;
  localparam logic [7:0] PLIC_THRESHOLD_OFFSET = 8'h8C;
  localparam logic [7:0] PLIC_CLAIM_OFFSET     = 8'h90;

  typedef logic [$clog2(PLIC_NUM_SRC)-1:0] plic_id_t;
  typedef logic [PLIC_PRIO_WIDTH-1:0]      plic_prio_t;

endpackage

// File: rtl/uninasoc_plic_gateway.sv
// Per-source interrupt gateway: edge/level detection, pending latch and
// in-flight tracking between claim and complete.
module uninasoc_plic_gateway
  import uninasoc_pkg::*;
(
  input  logic clock_i,
  input  logic reset_ni,
  input  logic src_i,
  input  logic edge_i,
  input  logic claim_i,
  input  logic complete_i,
  output logic pending_o,
  output logic inflight_o
);

  logic src_q;
  logic pending_q, pending_d;
  logic inflight_q, inflight_d;
  logic set_s;

  // Trigger detection; a level source is gated off in its own claim cycle
  always_comb begin
    if (edge_i) begin
      set_s = src_i & ~src_q;
    end else begin
      set_s = src_i & ~inflight_q & ~claim_i;
    end
  end

  // Pending/in-flight next state; a new trigger beats a claim clear
  always_comb begin
    if (set_s) begin
      pending_d = 1'b1;
    end else if (claim_i) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
    if (claim_i) begin
      inflight_d = 1'b1;
    end else if (complete_i) begin
      inflight_d = 1'b0;
    end else begin
      inflight_d = inflight_q;
    end
  end

  // Gateway state registers
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      src_q      <= 1'b0;
      pending_q  <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      src_q      <= src_i;
      pending_q  <= pending_d;
      inflight_q <= inflight_d;
    end
  end

  assign pending_o  = pending_q;
  assign inflight_o = inflight_q;

endmodule

// File: rtl/uninasoc_plic_ctrl.sv
// Compact PLIC: per-source gateways, registered priority arbiter, and a
// single-cycle register port with claim/complete handshake.
module uninasoc_plic_ctrl
  import uninasoc_pkg::*;
#(
  parameter int unsigned NUM_SRC    = PLIC_NUM_SRC,
  parameter int unsigned PRIO_WIDTH = PLIC_PRIO_WIDTH
) (
  input  logic               clock_i,
  input  logic               reset_ni,
  input  logic [NUM_SRC-1:0] irq_src_i,
  input  logic               reg_req_i,
  input  logic               reg_we_i,
  input  logic [7:0]         reg_addr_i,
  input  logic [31:0]        reg_wdata_i,
  output logic [31:0]        reg_rdata_o,
  output logic               reg_ack_o,
  output logic               irq_o
);

  localparam int unsigned ID_W = $clog2(NUM_SRC);
  localparam logic [NUM_SRC-1:0] SRC_MASK = {{(NUM_SRC-1){1'b1}}, 1'b0};
  localparam logic [NUM_SRC-1:0] ONE_HOT0 = {{(NUM_SRC-1){1'b0}}, 1'b1};
  localparam logic [31:0] PRIO_IMPL = (NUM_SRC >= 32) ? 32'hFFFF_FFFF
                                                      : ((32'd1 << NUM_SRC) - 32'd1);

  logic [NUM_SRC-1:0]    pending_s, inflight_s, eligible_s;
  logic [NUM_SRC-1:0]    claim_sel_s, complete_sel_s;
  logic [NUM_SRC-1:0]    enable_q, enable_d, edge_q, edge_d;
  logic [PRIO_WIDTH-1:0] prio_q [NUM_SRC];
  logic [PRIO_WIDTH-1:0] prio_d [NUM_SRC];
  logic [PRIO_WIDTH-1:0] threshold_q, threshold_d;
  logic [ID_W-1:0]       best_id_q, best_id_d;
  logic [PRIO_WIDTH-1:0] best_prio_q, best_prio_d;
  logic                  irq_q, irq_d, ack_q;
  logic [31:0]           rdata_q, rdata_d;
  logic [7:0]            word_addr_s;
  logic [4:0]            prio_idx_s;
  logic                  wr_s, rd_s, prio_hit_s, claim_fire_s, complete_fire_s;
  logic                  unused_s;

  assign unused_s = ^{reg_addr_i[1:0], irq_src_i[0], claim_sel_s[0],
                      complete_sel_s[0], edge_q[0]};

  // Access decode
  always_comb begin
    word_addr_s = {reg_addr_i[7:2], 2'b00};
    prio_idx_s  = reg_addr_i[6:2];
    wr_s        = reg_req_i & reg_we_i;
    rd_s        = reg_req_i & ~reg_we_i;
    prio_hit_s  = ~reg_addr_i[7] & PRIO_IMPL[prio_idx_s];
  end

  for (genvar n = 1; n < NUM_SRC; n++) begin : g_gw
    uninasoc_plic_gateway u_gateway (
      .clock_i    (clock_i),
      .reset_ni   (reset_ni),
      .src_i      (irq_src_i[n]),
      .edge_i     (edge_q[n]),
      .claim_i    (claim_sel_s[n]),
      .complete_i (complete_sel_s[n]),
      .pending_o  (pending_s[n]),
      .inflight_o (inflight_s[n])
    );
  end
  assign pending_s[0]  = 1'b0;
  assign inflight_s[0] = 1'b0;

  // Claim takes the registered winner; complete only accepts a valid in-flight ID
  always_comb begin
    claim_fire_s    = rd_s && (word_addr_s == PLIC_CLAIM_OFFSET) && (best_prio_q != '0);
    complete_fire_s = wr_s && (word_addr_s == PLIC_CLAIM_OFFSET) &&
                      (reg_wdata_i != 32'd0) && (reg_wdata_i < NUM_SRC) &&
                      inflight_s[reg_wdata_i[ID_W-1:0]];
    claim_sel_s     = claim_fire_s ? (ONE_HOT0 << best_id_q) : '0;
    complete_sel_s  = complete_fire_s ? (ONE_HOT0 << reg_wdata_i[ID_W-1:0]) : '0;
  end

  // Arbiter: strict '>' while scanning upwards keeps ties on the lowest ID
  always_comb begin
    best_id_d   = '0;
    best_prio_d = '0;
    eligible_s  = '0;
    for (int unsigned n = 1; n < NUM_SRC; n++) begin
      eligible_s[n] = pending_s[n] & enable_q[n] & ~inflight_s[n] & (prio_q[n] != '0);
      best_id_d     = (eligible_s[n] && (prio_q[n] > best_prio_d)) ? ID_W'(n) : best_id_d;
      best_prio_d   = (eligible_s[n] && (prio_q[n] > best_prio_d)) ? prio_q[n] : best_prio_d;
    end
    irq_d = (best_prio_d > threshold_q);
  end

  // Read data mux
  always_comb begin
    rdata_d = 32'd0;
    if (rd_s) begin
      if (prio_hit_s) begin
        rdata_d = 32'(prio_q[prio_idx_s]);
      end else begin
        case (word_addr_s)
          PLIC_PENDING_OFFSET:   rdata_d = 32'(pending_s);
          PLIC_ENABLE_OFFSET:    rdata_d = 32'(enable_q);
          PLIC_EDGE_OFFSET:      rdata_d = 32'(edge_q);
          PLIC_THRESHOLD_OFFSET: rdata_d = 32'(threshold_q);
          PLIC_CLAIM_OFFSET:     rdata_d = 32'(best_id_q);
          default:               rdata_d = 32'd0;
        endcase
      end
    end else begin
      rdata_d = 32'd0;
    end
  end

  // Configuration writes; bit 0 / PRIORITY[0] stay hardwired to zero
  always_comb begin
    enable_d    = enable_q;
    edge_d      = edge_q;
    threshold_d = threshold_q;
    prio_d      = prio_q;
    if (wr_s) begin
      if (prio_hit_s) begin
        if (prio_idx_s != 5'd0) begin
          prio_d[prio_idx_s] = reg_wdata_i[PRIO_WIDTH-1:0];
        end else begin
          prio_d = prio_q;
        end
      end else begin
        case (word_addr_s)
          PLIC_ENABLE_OFFSET:    enable_d    = reg_wdata_i[NUM_SRC-1:0] & SRC_MASK;
          PLIC_EDGE_OFFSET:      edge_d      = reg_wdata_i[NUM_SRC-1:0] & SRC_MASK;
          PLIC_THRESHOLD_OFFSET: threshold_d = reg_wdata_i[PRIO_WIDTH-1:0];
          default:               threshold_d = threshold_q;
        endcase
      end
    end else begin
      threshold_d = threshold_q;
    end
  end

  // Controller registers
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      enable_q    <= '0;
      edge_q      <= '0;
      threshold_q <= '0;
      best_id_q   <= '0;
      best_prio_q <= '0;
      irq_q       <= 1'b0;
      ack_q       <= 1'b0;
      rdata_q     <= 32'd0;
      for (int i = 0; i < int'(NUM_SRC); i++) begin
        prio_q[i] <= '0;
      end
    end else begin
      enable_q    <= enable_d;
      edge_q      <= edge_d;
      threshold_q <= threshold_d;
      best_id_q   <= best_id_d;
      best_prio_q <= best_prio_d;
      irq_q       <= irq_d;
      ack_q       <= reg_req_i;
      rdata_q     <= rdata_d;
      for (int i = 0; i < int'(NUM_SRC); i++) begin
        prio_q[i] <= prio_d[i];
      end
    end
  end

  assign reg_rdata_o = rdata_q;
  assign reg_ack_o   = ack_q;
  assign irq_o       = irq_q;

endmodule
